// File: rtl/cpu_datapath.sv
// 16-bit CPU datapath: 16x16 register file, 8-function ALU, 256x16 synchronous
// data memory with a registered output, and a write-back source selector.
module cpu_datapath (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        RF_W_en,
  input  logic [3:0]  RF_W_Addr,
  input  logic [3:0]  RF_Ra_Addr,
  input  logic [3:0]  RF_Rb_Addr,
  input  logic [1:0]  RF_s,
  input  logic [2:0]  ALU_s0,
  input  logic [7:0]  D_Addr,
  input  logic        D_Wr,
  output logic [15:0] ALU_inA,
  output logic [15:0] ALU_inB,
  output logic [15:0] ALU_out
);

  logic [15:0] rf_q  [16];
  logic [15:0] mem_q [256];
  logic [15:0] dout_q;
  logic [15:0] alu_d;
  logic [15:0] wb_d;

  assign ALU_inA = rf_q[RF_Ra_Addr];
  assign ALU_inB = rf_q[RF_Rb_Addr];
  assign ALU_out = alu_d;

  always_comb begin
    alu_d = 16'h0000;
    case (ALU_s0)
      3'd0: alu_d = 16'h0000;
      3'd1: alu_d = ALU_inA + ALU_inB;
      3'd2: alu_d = ALU_inA - ALU_inB;
      3'd3: alu_d = ALU_inA;
      3'd4: alu_d = ALU_inA ^ ALU_inB;
      3'd5: alu_d = ALU_inA | ALU_inB;
      3'd6: alu_d = ALU_inA & ALU_inB;
      3'd7: alu_d = ALU_inA + 16'd1;
      default: alu_d = 16'h0000;
    endcase
  end

  always_comb begin
    wb_d = 16'h0000;
    case (RF_s)
      2'b00:   wb_d = alu_d;
      2'b01:   wb_d = dout_q;
      default: wb_d = 16'h0000;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= 16'h0000;
    end else if (RF_W_en) begin
      rf_q[RF_W_Addr] <= wb_d;
    end
  end

  // The array itself has no reset; stores are still blocked while reset is held.
  always_ff @(posedge Clock) begin
    if (D_Wr && Reset_n) mem_q[D_Addr] <= ALU_inA;
  end

  // Write-through: a store returns its own data on the same edge.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)  dout_q <= 16'h0000;
    else if (D_Wr) dout_q <= ALU_inA;
    else           dout_q <= mem_q[D_Addr];
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed sequences, an ALU vector table,
// and randomized traffic checked against an array-based reference model.
`timescale 1ns/100ps
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rf_w_en;
  logic [3:0]  rf_w_addr, rf_ra, rf_rb;
  logic [1:0]  rf_s;
  logic [2:0]  alu_s;
  logic [7:0]  d_addr;
  logic        d_wr;
  logic [15:0] alu_a, alu_b, alu_y;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_rf  [16];
  bit          m_rfv [16];
  logic [15:0] m_mem [256];
  bit          m_memv[256];
  logic [15:0] m_q;
  bit          m_qv;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] exp;
  } alu_vec_t;
  alu_vec_t vecs[8];

  cpu_datapath dut (
    .Clock(clk), .Reset_n(rst_n), .RF_W_en(rf_w_en), .RF_W_Addr(rf_w_addr),
    .RF_Ra_Addr(rf_ra), .RF_Rb_Addr(rf_rb), .RF_s(rf_s), .ALU_s0(alu_s),
    .D_Addr(d_addr), .D_Wr(d_wr), .ALU_inA(alu_a), .ALU_inB(alu_b), .ALU_out(alu_y)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_ref(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    case (s)
      3'd0: return 16'h0000;
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a;
      3'd4: return a ^ b;
      3'd5: return a | b;
      3'd6: return a & b;
      default: return a + 16'd1;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_rf[i]  = 16'h0000;
      m_rfv[i] = 1'b1;
    end
    m_q  = 16'h0000;
    m_qv = 1'b1;
  endtask

  task automatic check_ports();
    if (m_rfv[rf_ra]) check("port_a", alu_a, m_rf[rf_ra]);
    if (m_rfv[rf_rb]) check("port_b", alu_b, m_rf[rf_rb]);
    if (m_rfv[rf_ra] && m_rfv[rf_rb])
      check("alu_out", alu_y, alu_ref(alu_s, m_rf[rf_ra], m_rf[rf_rb]));
  endtask

  task automatic settle();
    #1;
    check_ports();
  endtask

  task automatic drive(input logic we, input logic [3:0] w, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [1:0] s, input logic [2:0] sel,
                       input logic [7:0] addr, input logic dwr);
    rf_w_en = we; rf_w_addr = w; rf_ra = ra; rf_rb = rb;
    rf_s = s; alu_s = sel; d_addr = addr; d_wr = dwr;
  endtask

  // One rising edge; the model applies the architectural rules to pre-edge values.
  task automatic cycle();
    logic [15:0] a, b, wb;
    bit          va, vb, wbv;
    a = m_rf[rf_ra]; va = m_rfv[rf_ra];
    b = m_rf[rf_rb]; vb = m_rfv[rf_rb];
    case (rf_s)
      2'b00:   begin wb = alu_ref(alu_s, a, b); wbv = va && vb; end
      2'b01:   begin wb = m_q; wbv = m_qv; end
      default: begin wb = 16'h0000; wbv = 1'b1; end
    endcase
    @(posedge clk);
    if (rst_n) begin
      if (rf_w_en) begin
        m_rf[rf_w_addr]  = wb;
        m_rfv[rf_w_addr] = wbv;
      end
      if (d_wr) begin
        m_mem[d_addr]  = a;
        m_memv[d_addr] = va;
      end
      m_q  = m_mem[d_addr];
      m_qv = m_memv[d_addr];
    end
    @(negedge clk);
  endtask

  task automatic sweep_regs();
    for (int i = 0; i < 8; i++) begin
      rf_ra = 4'(2 * i);
      rf_rb = 4'(2 * i + 1);
      #0.2;
      if (m_rfv[rf_ra]) check($sformatf("reg%0d", 2 * i), alu_a, m_rf[rf_ra]);
      if (m_rfv[rf_rb]) check($sformatf("reg%0d", 2 * i + 1), alu_b, m_rf[rf_rb]);
    end
  endtask

  initial begin
    vecs[0] = '{3'd0, 16'd0};
    vecs[1] = '{3'd1, 16'd8};
    vecs[2] = '{3'd2, 16'd2};
    vecs[3] = '{3'd3, 16'd5};
    vecs[4] = '{3'd4, 16'd6};
    vecs[5] = '{3'd5, 16'd7};
    vecs[6] = '{3'd6, 16'd1};
    vecs[7] = '{3'd7, 16'd6};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    for (int i = 0; i < 256; i++) begin
      m_mem[i]  = 16'h0000;
      m_memv[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset pulse between edges after R1 has been made nonzero
    drive(1, 1, 1, 1, 0, 7, 0, 0);
    repeat (3) begin settle(); cycle(); end
    settle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_port_a", alu_a, 16'h0000);
    check("rst_port_b", alu_b, 16'h0000);
    check("rst_inc_out", alu_y, 16'h0001);
    rst_n = 1'b1;

    // Increment loop: 15 edges
    drive(1, 1, 1, 1, 0, 7, 0, 0);
    repeat (15) begin settle(); cycle(); end
    settle();
    check("inc15", alu_a, 16'h000F);

    // Subtract wrap builds 0xFFFF, then increment wraps to zero
    drive(1, 2, 2, 2, 0, 7, 0, 0);
    settle(); cycle();
    drive(1, 1, 0, 2, 0, 2, 0, 0);
    settle();
    check("sub_wrap_out", alu_y, 16'hFFFF);
    cycle();
    drive(1, 1, 1, 1, 0, 7, 0, 0);
    settle();
    check("preload_ffff", alu_a, 16'hFFFF);
    check("inc_wrap_out", alu_y, 16'h0000);
    cycle();
    settle();
    check("inc_wrap", alu_a, 16'h0000);

    // Build R1=5, R2=3 by increments
    drive(1, 1, 1, 1, 0, 7, 0, 0);
    repeat (5) begin settle(); cycle(); end
    drive(1, 2, 2, 2, 0, 7, 0, 0);
    repeat (2) begin settle(); cycle(); end

    // ALU function table with A=R1, B=R2
    drive(0, 0, 1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      alu_s = vecs[i].sel;
      #0.2;
      check($sformatf("alu_sel%0d", i), alu_y, vecs[i].exp);
    end

    // Store R1 to 0x10 then load into R3 over two edges
    drive(0, 0, 1, 2, 0, 0, 8'h10, 1);
    settle(); cycle();
    drive(1, 3, 3, 2, 1, 0, 8'h10, 0);
    settle(); cycle();
    settle(); cycle();
    settle();
    check("load_r3", alu_a, 16'h0005);

    // Load latency from a fresh address holding a different value
    drive(0, 0, 2, 2, 0, 0, 8'h20, 1);
    settle(); cycle();
    drive(0, 0, 3, 3, 0, 0, 8'h10, 0);
    settle(); cycle();
    drive(1, 4, 4, 4, 1, 0, 8'h20, 0);
    settle(); cycle();
    settle();
    check("load_stale_q", alu_a, 16'h0005);
    cycle();
    settle();
    check("load_r4", alu_a, 16'h0003);

    // Write gating: five edges with no register write
    drive(0, 1, 1, 2, 0, 7, 8'h10, 0);
    repeat (5) begin settle(); cycle(); end
    sweep_regs();
    rf_ra = 4'd1;
    #0.2;
    check("gated_r1", alu_a, 16'h0005);

    // Selector codes 10 and 11 write zero
    drive(1, 1, 1, 2, 2'b10, 7, 0, 0);
    settle(); cycle();
    settle();
    check("sel10_zero", alu_a, 16'h0000);
    drive(1, 1, 1, 1, 0, 7, 0, 0);
    settle(); cycle();
    drive(1, 1, 1, 1, 2'b11, 7, 0, 0);
    settle(); cycle();
    settle();
    check("sel11_zero", alu_a, 16'h0000);

    // Async reset mid-loop, held across an edge, then counting restarts
    drive(1, 1, 1, 1, 0, 7, 0, 0);
    repeat (4) begin settle(); cycle(); end
    settle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midloop_rst", alu_a, 16'h0000);
    cycle();
    settle();
    check("rst_hold", alu_a, 16'h0000);
    rst_n = 1'b1;
    settle(); cycle();
    settle();
    check("restart", alu_a, 16'h0001);

    // Randomized: initialise every memory word, then mixed traffic
    for (int i = 0; i < 256; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 2'b00, 3'($urandom_range(0, 7)), 8'(i), 1'b1);
      settle(); cycle();
    end
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      settle();
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_ports();
        rst_n = 1'b1;
      end
      cycle();
    end
    settle();
    sweep_regs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

16-bit datapath for the team's simple CPU. It contains a 16x16 register file, an 8-function ALU, a 256x16 synchronous data memory, and a write-back source selector. The controller drives it with register addresses, ALU select, memory address and write strobes. The block exposes both ALU operands and the ALU result for observation and for the controller.

## Interface

Parameters: none. All widths are fixed.

Clocking: one clock; reset is asynchronous and active-low.

- Clock  in  1  rising-edge clock for all state
- Reset_n  in  1  asynchronous, active-low reset
- RF_W_en  in  1  register-file write enable
- RF_W_Addr  in  4  register-file write address
- RF_Ra_Addr  in  4  register-file read port A address
- RF_Rb_Addr  in  4  register-file read port B address
- RF_s  in  2  write-back source select
- ALU_s0  in  3  ALU function select
- D_Addr  in  8  data-memory address
- D_Wr  in  1  data-memory write enable
- ALU_inA  out  16  register-file port A data; also the ALU A operand and the memory write data
- ALU_inB  out  16  register-file port B data; also the ALU B operand
- ALU_out  out  16  ALU result (combinational)

## Operation

Register file (16 x 16 bits):
- Read ports A and B are combinational: ALU_inA = R[RF_Ra_Addr], ALU_inB = R[RF_Rb_Addr].
- On a rising edge with RF_W_en=1, write-back data is written to R[RF_W_Addr].
- Reset clears all 16 registers to 0x0000.

ALU (combinational, 16-bit, modulo 2^16, no flags or carry out):
- 0: 0x0000
- 1: A+B
- 2: A-B (two's complement)
- 3: A (pass-through)
- 4: A^B
- 5: A|B
- 6: A&B
- 7: A+1

Write-back select:
- RF_s=00: ALU result
- RF_s=01: data-memory output q
- RF_s=10 or 11: 0x0000

Data memory (256 x 16, single port):
- On a rising edge with D_Wr=1, mem[D_Addr] <= ALU_inA.
- The output register q <= mem[D_Addr] on every rising edge.
- Read-during-write to the same address returns the new data (write-through).
- The memory array has no reset and its contents are undefined until written.
- The q register resets to 0x0000.

## Timing

- ALU_inA, ALU_inB and ALU_out settle combinationally from register contents and input selects; there is no pipeline.
- ALU write-back: operands read, result computed and written in the same cycle. The new value is visible on the read ports right after the rising edge.
- Register read-during-write to the same address: the port shows the old value until the edge, then the new value.
- Memory load latency is 1 cycle:
  - Edge n captures q = mem[D_Addr].
  - With RF_s=01, edge n+1 writes q into the register file.
  - A load therefore needs 2 edges from address setup.
- With RF_s=01, each edge writes the previous cycle's q. When D_Wr=1 at the same address, that q already reflects the store.
- Reset mid-operation clears all registers and q immediately, independent of Clock. No write occurs on any edge while Reset_n=0. Normal operation resumes on the first rising edge after Reset_n rises.
- Increment wraps: 0xFFFF + 1 = 0x0000. Subtract wraps: 0x0000 - 0x0001 = 0xFFFF.

## Test plan

- Reset: pulse Reset_n low between edges → ALU_inA = ALU_inB = 0x0000 immediately, q = 0x0000, and with ALU_s0=7, ALU_out = 0x0001.
- Increment loop: ALU_s0=7, RF_s=00, RF_W_en=1, Ra=W=1, 15 edges → R1 = 0x000F. Preload R1 to 0xFFFF → one more edge gives 0x0000.
- All ALU functions:
  - Setup: build R1=5 and R2=3 via increments, then set Ra=1, Rb=2.
  - Required ALU_out for selects 0..7: 0, 8, 2, 5, 6, 7, 1, 6.
- Store/load:
  - With R1=5: D_Addr=0x10, D_Wr=1, one edge.
  - Then D_Wr=0, RF_s=01, W=3, two edges → R3 = 0x0005.
  - D_Addr=0x11 with 0x11 never written is not checked.
- Write gating and selector: RF_W_en=0 for 5 edges → all registers unchanged. RF_s=10 with RF_W_en=1, W=1 → R1 = 0x0000.
- Async reset mid-loop: during the increment loop, drop Reset_n mid-cycle → R1 = 0 before the next edge. Release → counting restarts from 0x0000 (first edge after release gives 0x0001).
